// File: rtl/branch_unit_bht.sv
// ---------------------------------------------------------------------------
// branch_unit_bht
//
// Execute-stage branch resolution unit with an integrated bimodal branch
// history table (BHT) of 2-bit saturating counters.
//
// Resolves conditional branches (signed/unsigned compares), JAL and JALR,
// compares the actual outcome with the fetch-stage prediction and issues a
// registered one-cycle redirect pulse on mispredict. Conditional branches
// train the BHT, which the fetch stage reads combinationally.
//
// Ports:
//   clk                   clock
//   rst_n                 asynchronous active-low reset
//   fetch_pc_in           fetch PC used for the prediction lookup
//   fetch_pred_taken_out  MSB of the indexed counter (combinational)
//   ex_valid_in           execute-stage instruction valid
//   opcode, funct3        instruction opcode and branch condition
//   pc_in                 PC of the executing instruction
//   rs1_value_in          operand 1
//   rs2_value_in          operand 2
//   imm_value_in          sign-extended immediate
//   pred_taken_in         direction predicted at fetch
//   pred_target_in        target predicted at fetch
//   flush_in              kill the execute-stage instruction
//   redirect_valid_out    mispredict pulse; fetch must restart
//   redirect_pc_out       restart PC (held between redirects)
//   branch_count_out      resolved control-flow instructions (saturating)
//   mispredict_count_out  mispredicts (saturating)
// ---------------------------------------------------------------------------
module branch_unit_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BHT_INIT    = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  fetch_pc_in,
    output logic             fetch_pred_taken_out,
    input  logic             ex_valid_in,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  rs1_value_in,
    input  logic [XLEN-1:0]  rs2_value_in,
    input  logic [XLEN-1:0]  imm_value_in,
    input  logic             pred_taken_in,
    input  logic [XLEN-1:0]  pred_target_in,
    input  logic             flush_in,
    output logic             redirect_valid_out,
    output logic [XLEN-1:0]  redirect_pc_out,
    output logic [CNT_W-1:0] branch_count_out,
    output logic [CNT_W-1:0] mispredict_count_out
);

    localparam int IW = $clog2(BHT_ENTRIES);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // 2-bit bimodal counter training, saturating at 0 and 3.
    function automatic logic [1:0] bht_train(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != 2'd3) r = c + 2'd1;
        end else begin
            if (c != 2'd0) r = c - 2'd1;
        end
        return r;
    endfunction

    logic [1:0]             bht [BHT_ENTRIES];
    logic [IW-1:0]          fetch_idx;
    logic [IW-1:0]          ex_idx;
    logic                   unused_fetch_bits;

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic [XLEN-1:0]        br_target_p0;
    logic [XLEN-1:0]        jalr_sum_p0;
    logic [XLEN-1:0]        seq_pc_p0;
    logic [XLEN-1:0]        target_p0;
    logic [XLEN-1:0]        next_pc_p0;
    logic                   is_cond_p0;
    logic                   is_jump_p0;
    logic                   taken_p0;
    logic                   vld_p0;
    logic                   resolve_p0;
    logic                   mispredict_p0;
    logic                   bht_we_p0;

    logic                   redirect_vld_p1;
    logic [XLEN-1:0]        redirect_pc_p1;
    logic [CNT_W-1:0]       branch_cnt_p1;
    logic [CNT_W-1:0]       mispredict_cnt_p1;

    // Word-aligned PCs: bits [1:0] and the bits above the index never select
    // a counter.
    assign fetch_idx         = fetch_pc_in[IW+1:2];
    assign ex_idx            = pc_in[IW+1:2];
    assign unused_fetch_bits = ^{fetch_pc_in[XLEN-1:IW+2], fetch_pc_in[1:0]};

    // The lookup reads the stored array, so a same-cycle update at the same
    // index is only visible after the edge (write-after-read).
    assign fetch_pred_taken_out = bht[fetch_idx][1];

    // ---- Stage p0: combinational resolution ----
    assign rs1_s        = rs1_value_in;
    assign rs2_s        = rs2_value_in;
    assign br_target_p0 = pc_in + imm_value_in;
    assign jalr_sum_p0  = rs1_value_in + imm_value_in;
    assign seq_pc_p0    = pc_in + XLEN'(4);
    assign vld_p0       = ex_valid_in & ~flush_in;

    always_comb begin
        is_cond_p0 = 1'b0;
        is_jump_p0 = 1'b0;
        taken_p0   = 1'b0;
        target_p0  = br_target_p0;
        case (opcode)
            OP_BRANCH: begin
                is_cond_p0 = 1'b1;
                case (funct3)
                    F3_BEQ:  taken_p0 = (rs1_value_in == rs2_value_in);
                    F3_BNE:  taken_p0 = (rs1_value_in != rs2_value_in);
                    F3_BLT:  taken_p0 = (rs1_s < rs2_s);
                    F3_BGE:  taken_p0 = (rs1_s >= rs2_s);
                    F3_BLTU: taken_p0 = (rs1_value_in < rs2_value_in);
                    F3_BGEU: taken_p0 = (rs1_value_in >= rs2_value_in);
                    // funct3 010/011 are not branches: nothing resolves.
                    default: is_cond_p0 = 1'b0;
                endcase
            end
            OP_JAL: begin
                is_jump_p0 = 1'b1;
                taken_p0   = 1'b1;
            end
            OP_JALR: begin
                is_jump_p0 = 1'b1;
                taken_p0   = 1'b1;
                target_p0  = {jalr_sum_p0[XLEN-1:1], 1'b0};
            end
            default: begin
                is_jump_p0 = 1'b0;
            end
        endcase
    end

    assign resolve_p0 = vld_p0 & (is_cond_p0 | is_jump_p0);
    assign next_pc_p0 = taken_p0 ? target_p0 : seq_pc_p0;
    assign bht_we_p0  = vld_p0 & is_cond_p0;

    // Both not-taken is always correct; the target only matters when both
    // sides agree on taken.
    assign mispredict_p0 = resolve_p0 &
                           ((taken_p0 != pred_taken_in) |
                            (taken_p0 & pred_taken_in & (target_p0 != pred_target_in)));

    // ---- Stage p1: registered redirect and statistics ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_vld_p1   <= 1'b0;
            redirect_pc_p1    <= '0;
            branch_cnt_p1     <= '0;
            mispredict_cnt_p1 <= '0;
        end else begin
            redirect_vld_p1 <= mispredict_p0;
            if (mispredict_p0) begin
                redirect_pc_p1 <= next_pc_p0;
            end
            if (resolve_p0) begin
                branch_cnt_p1 <= cnt_sat_inc(branch_cnt_p1);
            end
            if (mispredict_p0) begin
                mispredict_cnt_p1 <= cnt_sat_inc(mispredict_cnt_p1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'(BHT_INIT);
            end
        end else if (bht_we_p0) begin
            bht[ex_idx] <= bht_train(bht[ex_idx], taken_p0);
        end
    end

    assign redirect_valid_out   = redirect_vld_p1;
    assign redirect_pc_out      = redirect_pc_p1;
    assign branch_count_out     = branch_cnt_p1;
    assign mispredict_count_out = mispredict_cnt_p1;

endmodule
